// File: rtl/heartbeat_gen_if.sv
// Heartbeat LED output bundle between the generator and the board pin logic.
// Latency: none, this is wiring only.
// Backpressure: none, the LED drive is a free-running level.
interface heartbeat_gen_if;
    logic led;

    modport master (output led);
    modport slave  (input  led);
endinterface : heartbeat_gen_if

// File: rtl/heartbeat_gen.sv
// Free-running LED heartbeat: PULSE_CYCLES on-time every CYCLES_PER_SEC sysclk cycles.
// Latency: led is registered; the first pulse starts on the first edge after reset release.
// Backpressure: none; only sysrst (async, active-high) stops it. Macro HEARTBEAT_DOUBLE_BEAT_EN adds a second beat.
module heartbeat_gen #(
    parameter int unsigned CYCLES_PER_SEC = 100000000,
    parameter int unsigned PULSE_CYCLES   = 20000000,
    parameter bit          LED_ACTIVE_LOW = 1'b0
) (
    input  logic            sysclk,
    input  logic            sysrst,
    heartbeat_gen_if.master hb
);

    // Counter just wide enough to hold CYCLES_PER_SEC-1.
    localparam int unsigned CNT_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES_PER_SEC - 1);

`ifdef HEARTBEAT_DOUBLE_BEAT_EN
    // Second beat window [2P, 3P); dropped entirely when it would not fit in the period.
    localparam int unsigned BEAT2_LO = 2 * PULSE_CYCLES;
    localparam int unsigned BEAT2_HI = 3 * PULSE_CYCLES;
    localparam bit          BEAT2_EN = (BEAT2_HI <= CYCLES_PER_SEC);
`endif

    // A one-cycle period cannot show a pulse; refuse to build it.
    generate
        if (CYCLES_PER_SEC < 2) begin : gen_bad_period
            $error("heartbeat_gen: CYCLES_PER_SEC must be >= 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             on_q;
    logic             on_d;
    logic [31:0]      cnt_ext;

    // Next count: wrap exactly at CYCLES_PER_SEC-1 so the count never exceeds it.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
        end
    end

    // Pulse decode at full 32-bit width so large PULSE_CYCLES values never truncate.
    always_comb begin
        cnt_ext = 32'(cnt_q);
        on_d    = (cnt_ext < PULSE_CYCLES);
`ifdef HEARTBEAT_DOUBLE_BEAT_EN
        if (BEAT2_EN && (cnt_ext >= BEAT2_LO) && (cnt_ext < BEAT2_HI)) begin
            on_d = 1'b1;
        end
`endif
    end

    // State registers; reset forces the LED dark immediately, without a clock.
    always_ff @(posedge sysclk or posedge sysrst) begin
        if (sysrst) begin
            cnt_q <= '0;
            on_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            on_q  <= on_d;
        end
    end

    // Polarity is a constant, so led is the on flop's output with no input path.
    assign hb.led = on_q ^ LED_ACTIVE_LOW;

endmodule : heartbeat_gen

// File: tb/tb_heartbeat_gen.sv
// Scoreboard bench for heartbeat_gen across several parameter sets.
// Expected LED levels are pushed per cycle by the stimulus process and popped at negedge.
// Also covers async mid-pulse reset, pulse width, rise count and period of a non-power-of-two wrap.
module tb_heartbeat_gen;

    localparam int ND = 7;
    localparam int CPS [ND] = '{100, 100, 100, 100, 100, 7, 100};
    localparam int PUL [ND] = '{ 10,   0, 100,  10,  40, 3, 150};
    localparam int ALO [ND] = '{  0,   0,   0,   1,   0, 0,   0};

    typedef struct {
        int   id;
        int   k;
        logic exp;
    } exp_t;

    logic          sysclk;
    logic          sysrst;
    logic [ND-1:0] leds;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   phase    = 0;
    int   rises0   = 0;

    generate
        for (genvar g = 0; g < ND; g++) begin : gen_dut
            heartbeat_gen_if hif ();
            heartbeat_gen #(
                .CYCLES_PER_SEC (CPS[g]),
                .PULSE_CYCLES   (PUL[g]),
                .LED_ACTIVE_LOW (ALO[g] != 0)
            ) u_dut (
                .sysclk (sysclk),
                .sysrst (sysrst),
                .hb     (hif.master)
            );
            assign leds[g] = hif.led;
        end
    endgenerate

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Expected LED level after k rising edges since reset release (k=0: in reset or no edge yet).
    function automatic logic exp_led(input int g, input int k);
        int   m;
        logic on;
        on = 1'b0;
        if (k > 0) begin
            m  = (k - 1) % CPS[g];
            on = (m < PUL[g]);
`ifdef HEARTBEAT_DOUBLE_BEAT_EN
            if ((3 * PUL[g] <= CPS[g]) && (m >= 2 * PUL[g]) && (m < 3 * PUL[g])) on = 1'b1;
`endif
        end
        return on ^ (ALO[g] != 0);
    endfunction

    task automatic push_all(input int k);
        exp_t e;
        for (int g = 0; g < ND; g++) begin
            e.id  = g;
            e.k   = k;
            e.exp = exp_led(g, k);
            sb_q.push_back(e);
        end
    endtask

    // Monitor: pop and compare every pending expectation, plus shape checks.
    initial begin : monitor
        exp_t e;
        int   cyc;
        int   hi_run;
        int   last5;
        logic prev0;
        logic prev5;
        cyc    = 0;
        hi_run = 0;
        last5  = -1;
        prev0  = 1'b0;
        prev5  = 1'b0;
        forever begin
            @(negedge sysclk);
            cyc++;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("led dut%0d k=%0d", e.id, e.k), 32'(leds[e.id]), 32'(e.exp));
            end
            check("dut5 cnt below 7", 32'(gen_dut[5].u_dut.cnt_q < 3'd7), 32'd1);
            if (sysrst) begin
                hi_run = 0;
                last5  = -1;
                prev0  = 1'b0;
                prev5  = 1'b0;
            end else begin
                if (leds[0] === 1'b1) begin
                    hi_run++;
                end else if (hi_run > 0) begin
                    check("dut0 pulse width", hi_run, 10);
                    hi_run = 0;
                end
                if (leds[0] === 1'b1 && !prev0 && phase == 1) rises0++;
                prev0 = leds[0];
                if (leds[5] === 1'b1 && !prev5) begin
                    if (last5 >= 0) check("dut5 period", cyc - last5, 7);
                    last5 = cyc;
                end
                prev5 = leds[5];
            end
        end
    end

    // Stimulus: reset, 1000 free-running cycles, async mid-pulse reset, 300 more cycles.
    initial begin : stim
        int k;
        int exp_rises;
        sysrst = 1'b1;
        repeat (5) begin
            @(posedge sysclk);
            push_all(0);
        end
        #3 sysrst = 1'b0;

        phase = 1;
        for (k = 1; k <= 1000; k++) begin
            @(posedge sysclk);
            push_all(k);
        end
        @(negedge sysclk);
        #1;
        phase = 2;
`ifdef HEARTBEAT_DOUBLE_BEAT_EN
        exp_rises = 20;
`else
        exp_rises = 10;
`endif
        check("dut0 rises in 1000 cycles", rises0, exp_rises);

        for (k = 1001; k <= 1004; k++) begin
            @(posedge sysclk);
            push_all(k);
        end
        @(posedge sysclk);
        #1;
        check("dut0 mid-pulse before reset", 32'(leds[0]), 32'(exp_led(0, 1005)));
        #1 sysrst = 1'b1;
        #1;
        check("dut0 async reset drop", 32'(leds[0]), 32'd0);
        check("dut3 async reset inactive", 32'(leds[3]), 32'd1);
        push_all(0);
        repeat (3) begin
            @(posedge sysclk);
            push_all(0);
        end
        #3 sysrst = 1'b0;

        for (k = 1; k <= 300; k++) begin
            @(posedge sysclk);
            push_all(k);
        end
        @(negedge sysclk);
        #1;
        check("scoreboard drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_heartbeat_gen
